uart_tx_arbiter: RTL

//  - Shares one chu_uart slot's TX path among N byte-stream requesters; drives the slot bus (cs/write/addr/wr_data).
//  - After reset, programs the baud divisor once, then grants the TX FIFO per packet under round-robin arbitration.
//  - Sits between the client engines and the chu_uart slot.
//  - Never reads or pops the RX FIFO.

---
 rtl/uart_tx_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one chu_uart slot TX FIFO among N_REQ byte streams.
// Optional idle-grant timeout: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int          N_REQ       = 4,
    parameter logic [10:0] DVSR_INIT   = 11'd325,
    parameter int          TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [2:0]         grant_id,
    output logic               busy,
    output logic               init_done,
    output logic               uart_cs,
    output logic               uart_write,
    output logic               uart_read,
    output logic [4:0]         uart_addr,
    output logic [31:0]        uart_wr_data,
    input  logic [31:0]        uart_rd_data
);

    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;

    logic [1:0] state_q, state_d;
    logic [2:0] rr_q, rr_d;
    logic [2:0] grant_q, grant_d;
    logic       busy_q, busy_d;
    logic       init_q, init_d;

    logic       tx_full;
    logic       g_valid;
    logic       g_last;
    logic [7:0] g_byte;
    logic       found;
    logic [2:0] pick;
    logic [2:0] next_ptr;
    logic       wr;
    logic       unused_rd;

    assign tx_full   = uart_rd_data[9];
    assign unused_rd = ^{uart_rd_data[31:10], uart_rd_data[8:0]};

    // Mux out the owner's handshake signals without a variable-width index.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_byte  = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q == 3'(i)) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_byte  = req_data[8*i +: 8];
            end
        end
    end

    // First requesting index at or after rr_q, wrapping at N_REQ.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = 3'd0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            for (int j = 0; j < N_REQ; j++) begin
                if (!found && j == idx && req_valid[j]) begin
                    found = 1'b1;
                    pick  = 3'(j);
                end
            end
        end
    end

    assign next_ptr = (grant_q == 3'(N_REQ-1)) ? 3'd0 : grant_q + 3'd1;
    assign wr       = (state_q == S_SEND) && g_valid && !tx_full;

    always_comb begin
        uart_cs      = 1'b0;
        uart_write   = 1'b0;
        uart_addr    = 5'd0;
        uart_wr_data = 32'd0;
        req_ready    = '0;
        if (state_q == S_INIT && reset_n) begin
            uart_cs      = 1'b1;
            uart_write   = 1'b1;
            uart_addr    = 5'd1;
            uart_wr_data = {21'b0, DVSR_INIT};
        end else if (wr) begin
            uart_cs      = 1'b1;
            uart_write   = 1'b1;
            uart_addr    = 5'd2;
            uart_wr_data = {24'b0, g_byte};
            for (int i = 0; i < N_REQ; i++)
                req_ready[i] = (grant_q == 3'(i));
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        init_d  = init_q;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            S_INIT: begin
                state_d = S_IDLE;
                init_d  = 1'b1;
            end
            S_IDLE: begin
`ifdef UART_ARB_TIMEOUT_EN
                cnt_d = '0;
`endif
                if (found) begin
                    grant_d = pick;
                    busy_d  = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (wr && g_last) begin
                    busy_d  = 1'b0;
                    rr_d    = next_ptr;
                    state_d = S_IDLE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                // Only an absent owner counts; tx_full stalls keep valid high.
                if (wr) begin
                    cnt_d = '0;
                end else if (!g_valid) begin
                    if (cnt_q == TO_LAST) begin
                        busy_d  = 1'b0;
                        rr_d    = next_ptr;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_INIT;
            rr_q    <= 3'd0;
            grant_q <= 3'd0;
            busy_q  <= 1'b0;
            init_q  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            init_q  <= init_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign uart_read = 1'b0;
    assign grant_id  = grant_q;
    assign busy      = busy_q;
    assign init_done = init_q;

endmodule
